// File: rtl/sample_req_sequencer_if.sv
// Control/status bundle between the ANC sample sequencer and its environment.
// S_Out/R_Out are one-cycle strobes to an external RS flag (set/clear); Ack is a level
// sampled only while a request is waiting; there is no back-pressure on any signal.
interface sample_req_sequencer_if;
  logic        En;
  logic        Ack;
  logic        Ovr_Clr;
  logic        S_Out;
  logic        R_Out;
  logic        Busy;
  logic        Timeout;
  logic        Overrun;
  logic [15:0] Sample_Cnt;
  logic [1:0]  Dbg_State;

  modport slave (
    input  En, Ack, Ovr_Clr,
    output S_Out, R_Out, Busy, Timeout, Overrun, Sample_Cnt, Dbg_State
  );

  modport master (
    output En, Ack, Ovr_Clr,
    input  S_Out, R_Out, Busy, Timeout, Overrun, Sample_Cnt, Dbg_State
  );
endinterface

// File: rtl/sample_req_sequencer.sv
// Issues one set/clear request per sample period to the downstream "sample pending" RS flag,
// waits for pipeline Ack or a bounded timeout, and tracks overruns and completed samples.
module sample_req_sequencer #(
  parameter int unsigned DIV      = 1024,
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned TIMEOUT  = 512,
  parameter int unsigned TO_W     = 9,
  parameter logic [15:0] CNT_INIT = 16'h0000
) (
  input  logic                   Clk,
  input  logic                   Rst,
  sample_req_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SET  = 2'd1,
    WAIT = 2'd2,
    CLR  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(DIV - 1);
  localparam logic [TO_W-1:0]  WAIT_LAST = TO_W'(TIMEOUT - 1);

  state_t           state_q;
  logic [CNT_W-1:0] per_q;
  logic [CNT_W-1:0] per_d;
  logic [TO_W-1:0]  wait_q;
  logic             s_q;
  logic             r_q;
  logic             busy_q;
  logic             to_q;
  logic             ovr_q;
  logic [15:0]      cnt_q;
  logic             tick;

  // The period counter only runs while enabled; dropping En restarts the period from zero.
  assign tick = bus.En && (per_q == PER_LAST);

  always_comb begin
    per_d = '0;
    if (bus.En && (per_q != PER_LAST)) begin
      per_d = per_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      per_q   <= '0;
      wait_q  <= '0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= CNT_INIT;
    end else begin
      per_q <= per_d;
      s_q   <= 1'b0;
      r_q   <= 1'b0;
      to_q  <= 1'b0;

      // A tick that lands while a request is in flight is dropped; setting beats clearing.
      if (tick && (state_q != IDLE)) begin
        ovr_q <= 1'b1;
      end else if (bus.Ovr_Clr) begin
        ovr_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (tick) begin
            state_q <= SET;
            s_q     <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        SET: begin
          state_q <= WAIT;
          wait_q  <= '0;
        end
        WAIT: begin
          if (bus.Ack) begin
            state_q <= CLR;
            r_q     <= 1'b1;
            cnt_q   <= cnt_q + 16'd1;
          end else if (wait_q == WAIT_LAST) begin
            state_q <= CLR;
            r_q     <= 1'b1;
            to_q    <= 1'b1;
          end else begin
            wait_q <= wait_q + TO_W'(1);
          end
        end
        CLR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.S_Out      = s_q;
  assign bus.R_Out      = r_q;
  assign bus.Busy       = busy_q;
  assign bus.Timeout    = to_q;
  assign bus.Overrun    = ovr_q;
  assign bus.Sample_Cnt = cnt_q;
  assign bus.Dbg_State  = state_q;

  a_no_set_and_clear: assert property (@(posedge Clk) disable iff (Rst) !(s_q && r_q));
  a_timeout_with_clear: assert property (@(posedge Clk) disable iff (Rst) to_q |-> r_q);

endmodule

// File: tb/tb_sample_req_sequencer.sv
// Bench for sample_req_sequencer: two instances (DIV=8/TIMEOUT=4 and DIV=4/TIMEOUT=8 with a
// counter preloaded to 0xFFFF) checked every cycle against a request-level reference model.
module tb_sample_req_sequencer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  sample_req_sequencer_if bus_a ();
  sample_req_sequencer_if bus_b ();

  sample_req_sequencer #(.DIV(8), .CNT_W(3), .TIMEOUT(4), .TO_W(2), .CNT_INIT(16'h0000)) dut_a (
    .Clk (clk),
    .Rst (rst),
    .bus (bus_a.slave)
  );

  sample_req_sequencer #(.DIV(4), .CNT_W(2), .TIMEOUT(8), .TO_W(3), .CNT_INIT(16'hFFFF)) dut_b (
    .Clk (clk),
    .Rst (rst),
    .bus (bus_b.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_div  [2] = '{8, 4};
  int          m_tmo  [2] = '{4, 8};
  logic [15:0] m_init [2] = '{16'h0000, 16'hFFFF};
  int          m_pcnt [2];
  bit          m_inreq[2];
  bit          m_end  [2];
  int          m_age  [2];
  bit          m_to   [2];
  bit          m_ovr  [2];
  logic [15:0] m_cnt  [2];

  // age counts cycles since the set strobe; a request ends on the cycle after Ack or after
  // TIMEOUT waiting cycles have elapsed without one.
  task automatic model_step(input int i, input bit r, input bit en, input bit ack, input bit oclr);
    bit tick;
    if (r) begin
      m_pcnt[i] = 0; m_inreq[i] = 0; m_end[i] = 0; m_age[i] = 0;
      m_to[i] = 0; m_ovr[i] = 0; m_cnt[i] = m_init[i];
      return;
    end
    tick = en && (m_pcnt[i] == m_div[i] - 1);
    m_pcnt[i] = (!en || tick) ? 0 : m_pcnt[i] + 1;
    if (tick && m_inreq[i]) m_ovr[i] = 1;
    else if (oclr) m_ovr[i] = 0;
    m_to[i] = 0;
    if (!m_inreq[i]) begin
      if (tick) begin
        m_inreq[i] = 1; m_age[i] = 0; m_end[i] = 0;
      end
    end else if (m_end[i]) begin
      m_inreq[i] = 0; m_end[i] = 0;
    end else if (ack && m_age[i] > 0) begin
      m_end[i] = 1; m_cnt[i] = m_cnt[i] + 16'd1;
    end else if (m_age[i] == m_tmo[i]) begin
      m_end[i] = 1; m_to[i] = 1;
    end else begin
      m_age[i] = m_age[i] + 1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] exp_flags(input int i);
    return {m_inreq[i] && !m_end[i] && m_age[i] == 0, m_end[i], m_inreq[i], m_to[i], m_ovr[i]};
  endfunction

  // One clock: model steps on the edge with the inputs the DUT saw, outputs compared mid-cycle.
  task automatic cycle();
    @(posedge clk);
    model_step(0, rst, bus_a.En, bus_a.Ack, bus_a.Ovr_Clr);
    model_step(1, rst, bus_b.En, bus_b.Ack, bus_b.Ovr_Clr);
    @(negedge clk);
    check("a_flags", {bus_a.S_Out, bus_a.R_Out, bus_a.Busy, bus_a.Timeout, bus_a.Overrun}, exp_flags(0));
    check("a_cnt", bus_a.Sample_Cnt, m_cnt[0]);
    check("b_flags", {bus_b.S_Out, bus_b.R_Out, bus_b.Busy, bus_b.Timeout, bus_b.Overrun}, exp_flags(1));
    check("b_cnt", bus_b.Sample_Cnt, m_cnt[1]);
  endtask

  // ---------------- driver tasks ----------------
  int s_a[$], r_a[$], to_a[$], s_b[$], r_b[$], to_b[$];
  int busy_a, ovr_b, strobes;

  task automatic drive_idle();
    bus_a.En = 0; bus_a.Ack = 0; bus_a.Ovr_Clr = 0;
    bus_b.En = 0; bus_b.Ack = 0; bus_b.Ovr_Clr = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1;
    cycle();
    rst = 0;
    s_a.delete(); r_a.delete(); to_a.delete();
    s_b.delete(); r_b.delete(); to_b.delete();
    busy_a = 0; ovr_b = -1;
  endtask

  // Cycle k of a run is the k-th clock after reset release; outputs seen after it belong to k+1.
  task automatic run(input int n, input int ack_at, input int rst_at, input int en_off_at, input int oclr_at);
    for (int k = 0; k < n; k++) begin
      bus_a.En = (k < en_off_at); bus_b.En = (k < en_off_at);
      bus_a.Ack = (k == ack_at);  bus_b.Ack = (k == ack_at);
      bus_a.Ovr_Clr = (k == oclr_at); bus_b.Ovr_Clr = (k == oclr_at);
      rst = (k == rst_at);
      cycle();
      if (bus_a.S_Out)   s_a.push_back(k + 1);
      if (bus_a.R_Out)   r_a.push_back(k + 1);
      if (bus_a.Timeout) to_a.push_back(k + 1);
      if (bus_a.Busy)    busy_a++;
      if (bus_b.S_Out)   s_b.push_back(k + 1);
      if (bus_b.R_Out)   r_b.push_back(k + 1);
      if (bus_b.Timeout) to_b.push_back(k + 1);
      if (bus_b.Overrun && ovr_b < 0) ovr_b = k + 1;
    end
    rst = 0;
    drive_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    total = 0; bad = 0;
    rst = 1;
    drive_idle();
    cycle();
    cycle();
    rst = 0;
    strobes = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      strobes += bus_a.S_Out + bus_a.R_Out + bus_b.S_Out + bus_b.R_Out;
    end
    check("reset_no_strobes", strobes, 0);
    check("reset_cnt_a", bus_a.Sample_Cnt, 16'h0000);

    // normal request with Ack two cycles after the set strobe
    do_reset();
    run(14, 10, -1, 100, -1);
    check("t2_s_cycle", s_a.size() > 0 ? s_a[0] : -1, 8);
    check("t2_r_cycle", r_a.size() > 0 ? r_a[0] : -1, 11);
    check("t2_busy_len", busy_a, 4);
    check("t2_timeouts", to_a.size(), 0);
    check("t2_cnt", bus_a.Sample_Cnt, 1);

    // timeout with no Ack, then the next period's request
    do_reset();
    run(17, -1, -1, 100, -1);
    check("t3_s_cycle", s_a.size() > 0 ? s_a[0] : -1, 8);
    check("t3_r_cycle", r_a.size() > 0 ? r_a[0] : -1, 13);
    check("t3_to_cycle", to_a.size() > 0 ? to_a[0] : -1, 13);
    check("t3_s2_cycle", s_a.size() > 1 ? s_a[1] : -1, 16);
    check("t3_cnt", bus_a.Sample_Cnt, 0);

    // overrun on the fast instance; En dropped mid-request, then Overrun cleared
    do_reset();
    run(16, -1, -1, 9, 14);
    check("t4_ovr_cycle", ovr_b, 8);
    check("t4_s_count", s_b.size(), 1);
    check("t4_r_cycle", r_b.size() > 0 ? r_b[0] : -1, 13);
    check("t4_ovr_cleared", bus_b.Overrun, 0);

    // reset pulse while waiting
    do_reset();
    run(12, -1, 10, 100, -1);
    check("t5_no_r", r_a.size(), 0);
    check("t5_busy_len", busy_a, 3);
    check("t5_busy_end", bus_a.Busy, 0);
    check("t5_cnt_b", bus_b.Sample_Cnt, 16'hFFFF);

    // Ack on the final waiting cycle of both instances; b's counter wraps
    do_reset();
    run(14, 12, -1, 100, -1);
    check("t6_r_cycle_a", r_a.size() > 0 ? r_a[0] : -1, 13);
    check("t6_to_a", to_a.size(), 0);
    check("t6_cnt_a", bus_a.Sample_Cnt, 1);
    check("t6_r_cycle_b", r_b.size() > 0 ? r_b[0] : -1, 13);
    check("t6_to_b", to_b.size(), 0);
    check("t6_cnt_b_wrap", bus_b.Sample_Cnt, 16'h0000);

    // randomized traffic on both instances
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      bus_a.En      = ($urandom_range(0, 9) != 0);
      bus_a.Ack     = ($urandom_range(0, 3) == 0);
      bus_a.Ovr_Clr = ($urandom_range(0, 15) == 0);
      bus_b.En      = ($urandom_range(0, 9) != 0);
      bus_b.Ack     = ($urandom_range(0, 5) == 0);
      bus_b.Ovr_Clr = ($urandom_range(0, 15) == 0);
      rst           = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 0;
    drive_idle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
